fpdiv_ctrl: RTL and testbench

//   Sequencing FSM for the Goldschmidt divider datapath (fpdiv): drives muxa/muxb selects and
//   the rega/regb/regc load enables so one shared multiplier computes Q = x/d.

---
 rtl/fpdiv_ctrl_if.sv | 37 +++
 rtl/fpdiv_ctrl.sv | 153 +++++++++++++++
 tb/tb_fpdiv_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpdiv_ctrl_if.sv
// Control bundle between the issuing unit, the Goldschmidt
// sequencer and the fpdiv datapath control pins.
interface fpdiv_ctrl_if;
  logic       start;
  logic [1:0] sel_muxa;
  logic [1:0] sel_muxb;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       busy;
  logic       done;
  logic [3:0] iter;

  modport master (
    output start,
    input  sel_muxa,
    input  sel_muxb,
    input  loada,
    input  loadb,
    input  loadc,
    input  busy,
    input  done,
    input  iter
  );

  modport slave (
    input  start,
    output sel_muxa,
    output sel_muxb,
    output loada,
    output loadb,
    output loadc,
    output busy,
    output done,
    output iter
  );
endinterface

// File: rtl/fpdiv_ctrl.sv
// Goldschmidt divider sequencer: orders the multiply steps on the
// shared multiplier and times the register loads. Moore outputs.
module fpdiv_ctrl #(
  parameter int ITER    = 2,
  parameter int MUL_LAT = 1
) (
  input logic         clk,
  input logic         reset,
  fpdiv_ctrl_if.slave bus
);

  localparam int CW = $clog2(MUL_LAT) + 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(MUL_LAT - 1);
  localparam logic [3:0] ITER_LAST =
    4'((ITER > 0) ? ITER - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_Q0,
    S_D0,
    S_QI,
    S_DI,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    iter_q, iter_d;
  logic [1:0]    sela_q, sela_d;
  logic [1:0]    selb_q, selb_d;
  logic          loadab_q, loadab_d;
  logic          loadc_q, loadc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          last;
  logic          fin;

  assign last = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_Q0;
          cnt_d   = CNT_TOP;
          iter_d  = '0;
        end
      end
      S_Q0, S_D0, S_QI, S_DI: begin
        if (!last) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          cnt_d = CNT_TOP;
          case (state_q)
            S_Q0: state_d = S_D0;
            S_D0: state_d = (ITER == 0) ? S_DONE : S_QI;
            S_QI: state_d = S_DI;
            default: begin
              iter_d  = iter_q + 4'd1;
              state_d = (iter_q == ITER_LAST) ? S_DONE : S_QI;
            end
          endcase
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        iter_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        iter_d  = '0;
      end
    endcase
  end

  // Outputs decode the next state so they are valid the cycle it is entered.
  assign fin = (cnt_d == '0);

  always_comb begin
    sela_d   = 2'b00;
    selb_d   = 2'b00;
    loadab_d = 1'b0;
    loadc_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      S_Q0: begin
        sela_d  = 2'b10;
        selb_d  = 2'b01;
        loadc_d = fin;
        busy_d  = 1'b1;
      end
      S_D0: begin
        sela_d   = 2'b10;
        selb_d   = 2'b00;
        loadab_d = fin;
        busy_d   = 1'b1;
      end
      S_QI: begin
        sela_d  = 2'b00;
        selb_d  = 2'b11;
        loadc_d = fin;
        busy_d  = 1'b1;
      end
      S_DI: begin
        sela_d   = 2'b00;
        selb_d   = 2'b10;
        loadab_d = fin;
        busy_d   = 1'b1;
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      iter_q   <= '0;
      sela_q   <= 2'b00;
      selb_q   <= 2'b00;
      loadab_q <= 1'b0;
      loadc_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      iter_q   <= iter_d;
      sela_q   <= sela_d;
      selb_q   <= selb_d;
      loadab_q <= loadab_d;
      loadc_q  <= loadc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.sel_muxa = sela_q;
  assign bus.sel_muxb = selb_q;
  assign bus.loada    = loadab_q;
  assign bus.loadb    = loadab_q;
  assign bus.loadc    = loadc_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.iter     = iter_q;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Bench for fpdiv_ctrl: 16 instances over ITER 0..3 x MUL_LAT 1..4,
// each with a real-valued Goldschmidt datapath model.
module tb_fpdiv_ctrl;

  localparam int NI  = 16;
  localparam int DEF = 8;
  localparam int I0M3 = 2;
  localparam real X_V  = 1.5;
  localparam real D_V  = 1.25;
  localparam real IA_V = 0.796875;
  localparam real TOL  = 1.0 / 1048576.0;

  typedef struct packed {
    logic [1:0] sa;
    logic [1:0] sb;
    logic       la;
    logic       lb;
    logic       lc;
    logic       busy;
    logic       done;
    logic [3:0] it;
  } outs_t;

  typedef struct packed {
    logic  start;
    outs_t exp;
  } vec_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  int    cyc = 0;
  int    nvec = 0;
  int    nerr = 0;
  logic  st [NI];
  outs_t obs [NI];
  int    exp_q [NI][$];
  vec_t  tbl [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int it_of(int i);
    return i / 4;
  endfunction

  function automatic int ml_of(int i);
    return i % 4 + 1;
  endfunction

  function automatic int lat(int i);
    return (2 + 2 * it_of(i)) * ml_of(i) + 1;
  endfunction

  function automatic vec_t mk(logic s, logic [1:0] sa,
                              logic [1:0] sb, logic lab,
                              logic lc, logic bz, logic dn,
                              logic [3:0] it);
    vec_t v;
    v.start    = s;
    v.exp.sa   = sa;
    v.exp.sb   = sb;
    v.exp.la   = lab;
    v.exp.lb   = lab;
    v.exp.lc   = lc;
    v.exp.busy = bz;
    v.exp.done = dn;
    v.exp.it   = it;
    return v;
  endfunction

  function automatic real prod(logic [1:0] sa, logic [1:0] sb,
                               real ra, real rb, real rc);
    real a, b;
    case (sa)
      2'b00: a = ra;
      2'b01: a = D_V;
      2'b10: a = IA_V;
      default: a = 0.0;
    endcase
    case (sb)
      2'b00: b = D_V;
      2'b01: b = X_V;
      2'b10: b = rb;
      default: b = rc;
    endcase
    return a * b;
  endfunction

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  for (genvar i = 0; i < NI; i++) begin : g
    localparam int IT = i / 4;
    localparam int ML = i % 4 + 1;
    fpdiv_ctrl_if bs ();
    real ra = 0.0;
    real rb = 0.0;
    real rc = 0.0;

    assign bs.start = st[i];
    assign obs[i] = {bs.sel_muxa, bs.sel_muxb, bs.loada,
                     bs.loadb, bs.loadc, bs.busy, bs.done,
                     bs.iter};

    fpdiv_ctrl #(
      .ITER    (IT),
      .MUL_LAT (ML)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bs)
    );

    always @(posedge clk) begin
      if (bs.loadc)
        rc <= prod(bs.sel_muxa, bs.sel_muxb, ra, rb, rc);
      if (bs.loadb)
        rb <= prod(bs.sel_muxa, bs.sel_muxb, ra, rb, rc);
      if (bs.loada)
        ra <= 2.0 - prod(bs.sel_muxa, bs.sel_muxb, ra, rb, rc);
    end

    always @(negedge clk) begin : mon
      int  e;
      real err;
      if (bs.done) begin
        if (exp_q[i].size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_done[%0d]: got done at %0d, want none",
                   i, cyc);
        end else begin
          e = exp_q[i].pop_front();
          chk($sformatf("done_cycle[%0d]", i), cyc, e);
          if (IT >= 2) begin
            err = (rc > 1.2) ? rc - 1.2 : 1.2 - rc;
            nvec++;
            if (err > TOL) begin
              nerr++;
              $display("FAIL quotient[%0d]: got %f, want 1.2", i, rc);
            end
          end
        end
      end
      if ((bs.loadc && bs.loadb) || (bs.loada != bs.loadb) ||
          (bs.sel_muxa == 2'b11) || (bs.done && bs.busy)) begin
        nerr++;
        $display("FAIL invariant[%0d]: got outs %0h at %0d, want legal",
                 i, obs[i], cyc);
      end
    end
  end

  task automatic apply(int idx, string nm);
    for (int k = 0; k < tbl.size(); k++) begin
      st[idx] = tbl[k].start;
      if (tbl[k].start)
        exp_q[idx].push_back(cyc + lat(idx));
      chk($sformatf("%s_t%0d", nm, k), int'(obs[idx]),
          int'(tbl[k].exp));
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) st[i] = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    for (int i = 0; i < NI; i++)
      chk($sformatf("reset_outs[%0d]", i), int'(obs[i]), 0);

    // Defaults: one start pulse, cycle-exact output trace.
    tbl.delete();
    tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b10, 2'b01, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b11, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b10, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b11, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b10, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    apply(DEF, "def");

    // ITER=0, MUL_LAT=3: selects held, loads only in final cycle.
    tbl.delete();
    tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b10, 2'b01, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 2'b10, 2'b01, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 2'b10, 2'b01, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    apply(I0M3, "i0m3");

    // start held high: accepted only in IDLE, t0, t8, t16.
    exp_q[DEF].push_back(cyc + 7);
    exp_q[DEF].push_back(cyc + 15);
    exp_q[DEF].push_back(cyc + 23);
    for (int k = 0; k < 30; k++) begin
      st[DEF] = (k < 20);
      if (k == 7)  chk("hold_done_t7", int'(obs[DEF].done), 1);
      if (k == 8)  chk("hold_idle_t8", int'(obs[DEF].busy), 0);
      if (k == 9)  chk("hold_q0_t9", int'({obs[DEF].sa, obs[DEF].sb}),
                       4'b1001);
      if (k == 16) chk("hold_idle_t16", int'(obs[DEF].busy), 0);
      if (k == 17) chk("hold_busy_t17", int'(obs[DEF].busy), 1);
      if (k == 24) chk("hold_idle_t24", int'(obs[DEF]), 0);
      step();
    end
    chk("hold_pending", exp_q[DEF].size(), 0);

    // Reset mid-run at t=4: outputs clear without a clock edge.
    st[DEF] = 1'b1;
    exp_q[DEF].push_back(cyc + lat(DEF));
    step();
    st[DEF] = 1'b0;
    repeat (3) step();
    chk("pre_reset_busy", int'(obs[DEF].busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_reset_outs", int'(obs[DEF]), 0);
    exp_q[DEF].delete();
    step();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0 || k == 9)
        chk($sformatf("post_reset_idle_%0d", k), int'(obs[DEF]), 0);
      step();
    end

    // Sweep all configurations together.
    for (int i = 0; i < NI; i++) begin
      st[i] = 1'b1;
      exp_q[i].push_back(cyc + lat(i));
    end
    step();
    for (int i = 0; i < NI; i++) st[i] = 1'b0;
    for (int k = 0; k < 40; k++) step();
    for (int i = 0; i < NI; i++)
      chk($sformatf("sweep_pending[%0d]", i), exp_q[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
